irq_priority_scheduler: RTL
===========================

IRQ_PRIORITY_SCHEDULER -- requirements
Module: irq_priority_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: irq_req  in  8  raw interrupt request lines IR0..IR7, synchronous to clk.
REQ-004 SHALL have ports: ltim  in  1  trigger mode, 1=level, 0=rising edge.
REQ-005 SHALL have ports: imr  in  8  interrupt mask, 1=masked.
REQ-006 SHALL have ports: aeoi  in  1  automatic EOI on second acknowledge.
REQ-007 SHALL have ports: rotate_en  in  1  automatic priority rotation on EOI.
REQ-008 SHALL have ports: eoi_pulse  in  1  one-cycle EOI command strobe.
REQ-009 SHALL have ports: eoi_specific  in  1  1=specific EOI using eoi_level, 0=non-specific.
REQ-010 SHALL have ports: eoi_level  in  3  level targeted by a specific EOI.
REQ-011 SHALL have ports: inta_n  in  1  processor acknowledge, active-low, synchronous to clk.
REQ-012 SHALL have ports: int_out  out  1  interrupt request to processor.
REQ-013 SHALL have ports: irr  out  8  interrupt request register.
REQ-014 SHALL have ports: isr  out  8  in-service register.
REQ-015 SHALL have ports: inta_count  out  2  acknowledges received in the current sequence (0,1,2).
REQ-016 SHALL have ports: vector_valid  out  1  one-cycle strobe, vector_num is valid.
REQ-017 SHALL have ports: vector_num  out  3  acknowledged IR level.
REQ-018 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-019 SHALL detect an acknowledge edge as inta_n sampled 1 in the previous cycle and 0 in the current cycle; inta_n edges in IDLE are ignored.
REQ-020 SHALL set irr[i] in edge mode on a 0->1 transition of irq_req[i], and in level mode whenever irq_req[i]=1; in level mode irr[i] clears when irq_req[i]=0.
REQ-021 SHALL rank priority with a rotating pointer lowest_prio (reset 7): the highest priority is lowest_prio+1 mod 8, descending cyclically.
REQ-022 SHALL select the candidate as the highest-priority bit of irr & ~imr, and SHALL treat it as eligible only if its priority is strictly higher than every set bit of isr (fully nested).
REQ-023 SHALL implement the FSM IDLE -> WAIT_ACK1 -> WAIT_ACK2 -> IDLE.
REQ-024 IDLE: an eligible candidate sets int_out=1 in the next cycle, sets inta_count=0, and moves to WAIT_ACK1.
REQ-025 WAIT_ACK1: on an acknowledge edge, SHALL latch the current candidate into vector_num, set its isr bit, clear its irr bit, set inta_count=1, and move to WAIT_ACK2.
REQ-026 WAIT_ACK1, no candidate at the edge (request withdrawn or masked): SHALL latch vector_num=7 (spurious) and SHALL NOT change isr.
REQ-027 WAIT_ACK2: on an acknowledge edge, SHALL pulse vector_valid for one cycle, set inta_count=2, clear int_out, and return to IDLE.
REQ-028 WAIT_ACK2 with aeoi=1: SHALL clear isr[vector_num] in the same cycle; if rotate_en=1, SHALL set lowest_prio=vector_num; no effect for a spurious vector.
REQ-029 Non-specific EOI: SHALL clear the highest-priority set bit of isr; specific EOI: SHALL clear isr[eoi_level]; if rotate_en=1, SHALL set lowest_prio to the cleared level.
REQ-030 EOI with the targeted isr bit already 0: SHALL have no effect, including no rotation.
REQ-031 EOI and an acknowledge edge in the same cycle: SHALL compute the EOI from the pre-edge isr, apply both, and let the set win on the same bit.
REQ-032 A new request arriving in WAIT_ACK1/WAIT_ACK2: SHALL enter irr only; it becomes eligible after the return to IDLE.
REQ-033 Mask changes: SHALL leave irr unchanged; masked bits are never selected.

Reset
REQ-034 rst_n=0: SHALL asynchronously set int_out=0, irr=0, isr=0, inta_count=0, vector_valid=0, vector_num=0, lowest_prio=7, the previous-sample registers of irq_req and inta_n to 0 and 1 respectively, and the FSM to IDLE.
REQ-035 Reset mid-sequence: SHALL abort it with no vector_valid pulse; the first acknowledge edge after release is ignored.

Structure
REQ-036 The shared package pic_pkg SHALL hold the FSM state typedef, IRQ_W=8, and SPURIOUS_LEVEL=3'd7.
REQ-037 The combinational rotating find-first SHALL be the sub-module pic_prio_resolver (inputs: vector, pointer; outputs: found, level), instantiated once for irr&~imr and once for isr.

Verification
REQ-038 Edge mode, irq_req=0x24, two inta_n pulses -> int_out=1, vector_num=2, isr=0x04, irr=0x20, vector_valid pulses once.
REQ-039 isr=0x04, request IR5 -> int_out stays 0; non-specific EOI -> isr=0x00, then int_out=1 and vector_num=5.
REQ-040 aeoi=1, rotate_en=1, IR3 acknowledged -> isr=0x00, lowest_prio=3; a simultaneous IR2+IR4 request -> vector_num=4.
REQ-041 Level mode, IR6 raised then dropped before ACK1 -> vector_num=7, isr unchanged.
REQ-042 rst_n asserted in WAIT_ACK2 -> all outputs at reset values, no vector_valid.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8-level priority interrupt scheduler.
package pic_pkg;

  localparam int IRQ_W = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK1 = 2'd1,
    ST_WAIT_ACK2 = 2'd2
  } pic_state_e;

  // 0 = highest priority, 7 = lowest, relative to the rotating pointer.
  function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lowest);
    return 3'(level - lowest - 3'd1);
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating find-first: returns the highest-priority set bit, where priority
// starts at pointer+1 and descends cyclically down to pointer itself.
module pic_prio_resolver
  import pic_pkg::*;
(
  input  logic [IRQ_W-1:0] vector,
  input  logic [2:0]       pointer,
  output logic             found,
  output logic [2:0]       level
);

  // Scan from lowest to highest priority so the highest set bit is written last.
  always_comb begin
    found = 1'b0;
    level = 3'd0;
    for (int k = IRQ_W; k >= 1; k--) begin
      if (vector[3'(pointer + 3'(k))]) begin
        found = 1'b1;
        level = 3'(pointer + 3'(k));
      end
    end
  end

endmodule

// File: rtl/irq_priority_scheduler.sv
// Priority interrupt scheduler: request capture, fully nested priority with
// rotation, two-acknowledge vector handshake and EOI/AEOI handling.
//
// state        | meaning
// ST_IDLE      | no request presented; waiting for an eligible candidate
// ST_WAIT_ACK1 | int_out raised; first acknowledge latches the vector
// ST_WAIT_ACK2 | vector latched; second acknowledge publishes it
module irq_priority_scheduler
  import pic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq_req,
  input  logic             ltim,
  input  logic [IRQ_W-1:0] imr,
  input  logic             aeoi,
  input  logic             rotate_en,
  input  logic             eoi_pulse,
  input  logic             eoi_specific,
  input  logic [2:0]       eoi_level,
  input  logic             inta_n,
  output logic             int_out,
  output logic [IRQ_W-1:0] irr,
  output logic [IRQ_W-1:0] isr,
  output logic [1:0]       inta_count,
  output logic             vector_valid,
  output logic [2:0]       vector_num
);

  pic_state_e       state, state_next;
  logic [IRQ_W-1:0] irq_prev;
  logic             inta_prev;
  logic [2:0]       lowest_prio, lowest_prio_next;
  logic             spurious, spurious_next;

  logic [IRQ_W-1:0] irr_next, isr_next;
  logic             int_out_next, vector_valid_next;
  logic [1:0]       inta_count_next;
  logic [2:0]       vector_num_next;

  logic             cand_found, isr_found;
  logic [2:0]       cand_level, isr_level;
  logic             eligible;
  logic             ack_edge;

  logic [IRQ_W-1:0] irr_base, ack_set, eoi_clr, aeoi_clr;
  logic [2:0]       eoi_target;
  logic             eoi_hit, rot_ack;

  pic_prio_resolver u_cand_resolver (
    .vector  (irr & ~imr),
    .pointer (lowest_prio),
    .found   (cand_found),
    .level   (cand_level)
  );

  pic_prio_resolver u_isr_resolver (
    .vector  (isr),
    .pointer (lowest_prio),
    .found   (isr_found),
    .level   (isr_level)
  );

  assign eligible = cand_found &&
                    (!isr_found || (prio_rank(cand_level, lowest_prio) < prio_rank(isr_level, lowest_prio)));
  assign ack_edge = inta_prev & ~inta_n;

  always_comb begin
    state_next        = state;
    int_out_next      = int_out;
    inta_count_next   = inta_count;
    vector_valid_next = 1'b0;
    vector_num_next   = vector_num;
    spurious_next     = spurious;
    ack_set           = '0;
    aeoi_clr          = '0;
    rot_ack           = 1'b0;

    irr_base = ltim ? irq_req : (irr | (irq_req & ~irq_prev));

    // EOI is evaluated against the in-service state before any same-cycle acknowledge.
    eoi_target = eoi_specific ? eoi_level : isr_level;
    eoi_hit    = eoi_pulse && (eoi_specific ? isr[eoi_level] : isr_found);
    eoi_clr    = eoi_hit ? (IRQ_W'(1) << eoi_target) : '0;

    case (state)
      ST_IDLE: begin
        if (eligible) begin
          state_next      = ST_WAIT_ACK1;
          int_out_next    = 1'b1;
          inta_count_next = 2'd0;
        end
      end
      ST_WAIT_ACK1: begin
        if (ack_edge) begin
          state_next      = ST_WAIT_ACK2;
          inta_count_next = 2'd1;
          if (cand_found) begin
            vector_num_next = cand_level;
            ack_set         = IRQ_W'(1) << cand_level;
            spurious_next   = 1'b0;
          end else begin
            vector_num_next = SPURIOUS_LEVEL;
            spurious_next   = 1'b1;
          end
        end
      end
      ST_WAIT_ACK2: begin
        if (ack_edge) begin
          state_next        = ST_IDLE;
          vector_valid_next = 1'b1;
          inta_count_next   = 2'd2;
          int_out_next      = 1'b0;
          if (aeoi && !spurious) begin
            aeoi_clr = IRQ_W'(1) << vector_num;
            rot_ack  = rotate_en;
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        int_out_next = 1'b0;
      end
    endcase

    irr_next = irr_base & ~ack_set;
    isr_next = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;

    if (rot_ack)
      lowest_prio_next = vector_num;
    else if (eoi_hit && rotate_en)
      lowest_prio_next = eoi_target;
    else
      lowest_prio_next = lowest_prio;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      irq_prev     <= '0;
      inta_prev    <= 1'b1;
      lowest_prio  <= 3'd7;
      spurious     <= 1'b0;
      irr          <= '0;
      isr          <= '0;
      int_out      <= 1'b0;
      inta_count   <= 2'd0;
      vector_valid <= 1'b0;
      vector_num   <= 3'd0;
    end else begin
      state        <= state_next;
      irq_prev     <= irq_req;
      inta_prev    <= inta_n;
      lowest_prio  <= lowest_prio_next;
      spurious     <= spurious_next;
      irr          <= irr_next;
      isr          <= isr_next;
      int_out      <= int_out_next;
      inta_count   <= inta_count_next;
      vector_valid <= vector_valid_next;
      vector_num   <= vector_num_next;
    end
  end

endmodule
